// File: rtl/pipe_unfunnel_pkg.sv
// Shared definitions for the Echo request unfunnel: header layout, FSM states, request message.
package pipe_unfunnel_pkg;

    localparam int HDR_LEN_HI = 31;
    localparam int HDR_LEN_LO = 16;
    localparam int HDR_TAG_HI = 15;

    localparam int REQ_DATA_W = 96;
    localparam int REQ_TAG_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        DROP,
        HOLD
    } state_t;

    // Matches the request data struct on the decoder side: data above tag.
    typedef struct packed {
        logic [REQ_DATA_W-1:0] data;
        logic [REQ_TAG_W-1:0]  tag;
    } msg_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_unfunnel_if.sv
// Word-in / message-out handshake bundle; master is the unfunnel block, slave is its surroundings.
interface pipe_unfunnel_if
    import pipe_unfunnel_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int MAX_WORDS = 3,
    parameter int MSG_W     = WORD_W * (MAX_WORDS + 1)
);

    logic              in_enq__ENA;
    logic [WORD_W-1:0] in_enq_v;
    logic              in_enq__RDY;
    logic              out_enq__ENA;
    logic [MSG_W-1:0]  out_enq_v;
    logic              out_enq__RDY;

    modport master (
        input  in_enq__ENA, in_enq_v, out_enq__RDY,
        output in_enq__RDY, out_enq__ENA, out_enq_v
    );

    modport slave (
        output in_enq__ENA, in_enq_v, out_enq__RDY,
        input  in_enq__RDY, out_enq__ENA, out_enq_v
    );

endinterface

// File: rtl/pipe_unfunnel.sv
// Reassembles header-framed 32-bit words into one {data, tag} request message; oversized frames are dropped and counted.
// Message valid the edge after the last payload word; HOLD stalls input until the message is taken.
module pipe_unfunnel
    import pipe_unfunnel_pkg::*;
#(
    parameter  int WORD_W    = 32,
    parameter  int MAX_WORDS = 3,
    localparam int MSG_W     = WORD_W * (MAX_WORDS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    pipe_unfunnel_if.master    bus,
    output logic [15:0]        drop_count
);

    localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_t             state_q, state_d;
    logic [15:0]        rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [15:0]        drop_q, drop_d;

    logic               word_acc;
    logic               msg_acc;
    logic [15:0]        hdr_len;

    assign bus.in_enq__RDY  = (state_q != HOLD);
    assign bus.out_enq__ENA = (state_q == HOLD);
    assign bus.out_enq_v    = msg_q;
    assign drop_count       = drop_q;

    assign word_acc = bus.in_enq__ENA && (state_q != HOLD);
    assign msg_acc  = (state_q == HOLD) && bus.out_enq__RDY;
    assign hdr_len  = bus.in_enq_v[HDR_LEN_HI:HDR_LEN_LO];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        msg_d   = msg_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (word_acc) begin
                    // Clearing on every header keeps short frames zero-padded.
                    msg_d                = '0;
                    msg_d[HDR_TAG_HI:0]  = bus.in_enq_v[HDR_TAG_HI:0];
                    rem_d                = hdr_len;
                    idx_d                = '0;
                    if (hdr_len == 16'd0)
                        state_d = HOLD;
                    else if (hdr_len <= 16'(MAX_WORDS))
                        state_d = BODY;
                    else
                        state_d = DROP;
                end
            end
            BODY: begin
                if (word_acc) begin
                    msg_d[MSG_W-1 - WORD_W*int'(idx_q) -: WORD_W] = bus.in_enq_v;
                    idx_d = idx_q + 1'b1;
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1)
                        state_d = HOLD;
                end
            end
            DROP: begin
                if (word_acc) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = IDLE;
                        drop_d  = sat_inc16(drop_q);
                    end
                end
            end
            HOLD: begin
                if (msg_acc)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            msg_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pipe_unfunnel.sv
// Directed and random frames against a queue-based model of frame reassembly and drop counting.
module tb_pipe_unfunnel;
    import pipe_unfunnel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drop_count;

    pipe_unfunnel_if bus ();

    pipe_unfunnel dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    msg_t        exp_q[$];
    logic [15:0] exp_drop;
    bit          rand_rdy = 1'b0;
    logic [31:0] pl [8];

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Payload word k lands MSB-first in the 96-bit data field.
    function automatic msg_t model_msg(input int n, input logic [15:0] tag);
        msg_t m;
        m.tag  = {16'h0, tag};
        m.data = '0;
        for (int k = 1; k <= n; k++)
            m.data = m.data | (96'(pl[k-1]) << (32 * (3 - k)));
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the word transferred.
    task automatic send_word(input logic [31:0] w);
        int b = 0;
        while (!bus.in_enq__RDY && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (!bus.in_enq__RDY) begin
            chk_eq("in_rdy_timeout", bus.in_enq__RDY, 1);
        end else begin
            bus.in_enq__ENA = 1'b1;
            bus.in_enq_v    = w;
            @(posedge clk); #1;
            bus.in_enq__ENA = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input logic [15:0] tag);
        if (n <= 3) exp_q.push_back(model_msg(n, tag));
        send_word({16'(n), tag});
        for (int k = 0; k < n; k++) send_word(pl[k]);
        if (n > 3) begin
            exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
            chk_eq("drop_count", drop_count, exp_drop);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) bus.out_enq__RDY = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard plus stall-stability checks, sampled away from the active edge.
    initial begin
        logic         prev_stall = 1'b0;
        logic [127:0] prev_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_eq("hold_ena", bus.out_enq__ENA, 1);
                    chk_eq("hold_stable", bus.out_enq_v, prev_v);
                    chk_eq("hold_in_rdy", bus.in_enq__RDY, 0);
                end
                if (bus.out_enq__ENA && bus.out_enq__RDY) begin
                    if (exp_q.size() == 0) chk_eq("spurious_msg", exp_q.size(), 1);
                    else                   chk_eq("msg", bus.out_enq_v, exp_q.pop_front());
                end
                prev_stall = bus.out_enq__ENA && !bus.out_enq__RDY;
                prev_v     = bus.out_enq_v;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst               = 1'b1;
        bus.in_enq__ENA   = 1'b0;
        bus.in_enq_v      = '0;
        bus.out_enq__RDY  = 1'b1;
        exp_drop          = '0;
        foreach (pl[i]) pl[i] = '0;
        #12;
        chk_eq("rst_in_rdy", bus.in_enq__RDY, 1);
        chk_eq("rst_out_ena", bus.out_enq__ENA, 0);
        chk_eq("rst_out_v", bus.out_enq_v, 0);
        chk_eq("rst_drop", drop_count, 0);
        @(negedge clk) rst = 1'b0;
        step();

        // Two-word frame, downstream always ready.
        pl[0] = 32'h1111_1111; pl[1] = 32'h2222_2222;
        send_frame(2, 16'h0001);
        chk_eq("t1_ena_after_last", bus.out_enq__ENA, 1);
        chk_eq("t1_value", bus.out_enq_v, 128'h11111111_22222222_00000000_00000001);
        step();
        chk_eq("t1_ena_one_cycle", bus.out_enq__ENA, 0);

        // Full frame held under backpressure.
        bus.out_enq__RDY = 1'b0;
        pl[0] = 32'hAAAA_0001; pl[1] = 32'hBBBB_0002; pl[2] = 32'hCCCC_0003;
        send_frame(3, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            chk_eq("t2_in_rdy_low", bus.in_enq__RDY, 0);
            step();
        end
        chk_eq("t2_value", bus.out_enq_v, 128'hAAAA0001_BBBB0002_CCCC0003_00000002);
        bus.out_enq__RDY = 1'b1;
        step();
        chk_eq("t2_ena_done", bus.out_enq__ENA, 0);
        chk_eq("t2_in_rdy_back", bus.in_enq__RDY, 1);

        // Empty frame.
        send_frame(0, 16'h0007);
        chk_eq("t3_ena", bus.out_enq__ENA, 1);
        chk_eq("t3_value", bus.out_enq_v, 128'h7);
        step();

        // Oversized frame dropped, then a valid one.
        for (int i = 0; i < 5; i++) pl[i] = 32'h5000_0000 + 32'(i);
        send_frame(5, 16'h0003);
        chk_eq("t4_drop_one", drop_count, 16'd1);
        pl[0] = 32'hDEAD_BEEF;
        send_frame(1, 16'h0004);
        chk_eq("t4_value", bus.out_enq_v, 128'hDEADBEEF_00000000_00000000_00000004);
        step();

        // Reset in mid-frame.
        send_word(32'h0003_0001);
        send_word(32'h0123_4567);
        #2 rst = 1'b1;
        #1;
        chk_eq("t5_in_rdy", bus.in_enq__RDY, 1);
        chk_eq("t5_out_ena", bus.out_enq__ENA, 0);
        chk_eq("t5_out_v", bus.out_enq_v, 0);
        chk_eq("t5_drop", drop_count, 0);
        exp_drop = '0;
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        step();
        pl[0] = 32'h1234_5678;
        send_frame(1, 16'h0009);
        chk_eq("t5_reparse", bus.out_enq_v, 128'h12345678_00000000_00000000_00000009);
        step();

        // Random frames with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int k = 0; k < 8; k++) pl[k] = $urandom;
            send_frame(n, 16'($urandom));
        end
        rand_rdy = 1'b0;
        bus.out_enq__RDY = 1'b1;
        b = 0;
        while ((exp_q.size() != 0 || bus.out_enq__ENA) && b < 100) begin
            step();
            b++;
        end
        chk_eq("drain_empty", exp_q.size(), 0);

        // Counter saturation from just below the ceiling.
        force dut.drop_q = 16'hFFFD;
        #1 release dut.drop_q;
        exp_drop = 16'hFFFD;
        for (int i = 0; i < 4; i++) pl[i] = 32'hFFFF_0000 + 32'(i);
        for (int f = 0; f < 4; f++) send_frame(4, 16'h00AA);
        chk_eq("sat_hold", drop_count, 16'hFFFF);
        chk_eq("sat_no_msg", exp_q.size(), 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_unfunnel.md
# pipe_unfunnel

Receive-side unfunnel for the Echo request path. Accepts a 32-bit word stream, framed by a header word carrying tag and payload length, on a PipeIn-style server port. Reassembles each frame into one packed request message (`{data, tag}`) and delivers it on a PipeIn-style client port. It is the inverse of the funnel that narrows request messages onto the 32-bit NOC link, and sits between the link receiver and the request decoder.

## Interface
Parameters:
- `WORD_W`, default 32: width of one link word.
- `MAX_WORDS`, default 3: maximum payload words per frame.
- `MSG_W`, default `WORD_W*(MAX_WORDS+1)` = 128: output message width. Derived; do not override.

Ports:
- `CLK` in 1: sole clock. All state updates on the rising edge.
- `RST` in 1: reset. Asynchronous and active-high; asserting it clears all state immediately.
- `in$enq__ENA` in 1: upstream word valid. Asserted only while `in$enq__RDY` is high.
- `in$enq$v` in `WORD_W`: upstream word.
- `in$enq__RDY` out 1: block can take a word.
- `out$enq__ENA` out 1: assembled message valid.
- `out$enq$v` out `MSG_W`: message. `[MSG_W-1:32]` = data, `[31:0]` = tag.
- `out$enq__RDY` in 1: downstream accepts.
- `drop_count` out 16: saturating count of discarded malformed frames.

## Operation
- Transfers:
  - A word transfers when `in$enq__ENA && in$enq__RDY`.
  - A message transfers when `out$enq__ENA && out$enq__RDY`.
- Header word fields:
  - `[31:16]` = N, the payload word count.
  - `[15:0]` = tag, zero-extended into `out$enq$v[31:0]`.
- Payload placement: payload word k (k = 1..N) goes to `data[96-32(k-1)-1 -: 32]`, MSB-first. Unfilled data words are zero. The data register is cleared on every accepted header.
- States:
  - `IDLE`: expects a header.
    - N = 0 → `HOLD`.
    - 1 ≤ N ≤ `MAX_WORDS` → `BODY`, with remaining = N and index = 0.
    - N > `MAX_WORDS` → `DROP`, with remaining = N.
  - `BODY`: each accepted word is written at index, then index++ and remaining--. The word that makes remaining 0 moves the block to `HOLD`.
  - `DROP`: each accepted word is discarded and remaining--. The last word moves the block to `IDLE` and increments `drop_count`; the count saturates at 0xFFFF.
  - `HOLD`: `out$enq__ENA` = 1 and `out$enq$v` is held stable. On message transfer → `IDLE`.
- `in$enq__RDY` = (state != `HOLD`). It is registered-state decode only, with no combinational path from `out$enq__RDY`.
- `out$enq__ENA` = (state == `HOLD`). It has no combinational dependence on `out$enq__RDY`.
- Reset values:
  - state = `IDLE`, so `in$enq__RDY` = 1 and `out$enq__ENA` = 0.
  - `out$enq$v` = 0.
  - `drop_count` = 0.
  - remaining and index = 0.
- Reset mid-frame: the partial frame is lost. The first word after reset is treated as a header.

## Timing
- The last payload word accepted at edge t gives `out$enq__ENA` = 1 from t until the edge where the message transfers.
- A header with N = 0 accepted at t gives `out$enq__ENA` at t.
- Throughput: one frame per N+2 cycles at best, counting header, N words and one `HOLD` cycle. `in$enq__RDY` returns in the cycle after the message transfer.
- Backpressure: `HOLD` persists indefinitely while `out$enq__RDY` = 0. Upstream is stalled by `in$enq__RDY` = 0 for that whole time.
- `DROP` of N words takes N accepted-word cycles. `drop_count` updates on the edge of the last discarded word.

## Structure
- Shared package `pipe_unfunnel_pkg` holds:
  - header field constants (`HDR_LEN_HI`=31, `HDR_LEN_LO`=16, `HDR_TAG_HI`=15);
  - the state enum `{IDLE, BODY, DROP, HOLD}`;
  - the message typedef matching the request data struct (data, then tag).
- Single module, no sub-module. The FSM, the 16-bit remaining counter, the 2-bit index and the `MSG_W` hold register all live in this module.

## Test plan
- Header 0x0002_0001 then words 0x1111_1111, 0x2222_2222, with `out$enq__RDY`=1 → one message, data = 0x11111111_22222222_00000000, tag = 1. `out$enq__ENA` high for exactly one cycle, one edge after the last word.
- Header 0x0003_0002 then words A, B, C, with `out$enq__RDY` held 0 for 5 cycles → `out$enq__ENA` and `out$enq$v` stay stable and `in$enq__RDY` = 0 throughout. Message transfers on the first cycle with RDY = 1.
- Header 0x0000_0007 → message with data 0 and tag 7, `out$enq__ENA` the cycle after the header.
- Header 0x0005_0003 plus 5 words, then a valid frame 0x0001_0004, 0xDEAD_BEEF → `drop_count` = 1. Only one message is emitted: data[95:64] = 0xDEADBEEF, tag = 4.
- `RST` pulsed after a header 0x0003_0001 and one payload word → outputs return to their reset values. The next word, 0x0001_0009, is parsed as a header.
- 0x10000 malformed frames (N=4) → `drop_count` saturates at 0xFFFF and does not wrap.
